uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised, buffered UART transmitter: the next generation of the single-byte serial TX engine. It accepts bytes through a valid/ready write port into an internal FIFO and serialises them LSB-first. Frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits) and baud divisor are runtime-configurable. It sits between the CPU's MMIO peripheral bus and the board TX pin, and sends frames back-to-back with no idle gap while the FIFO holds data.

## Interface
- `FIFO_DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `DIV_W`, default 16: width of the baud divisor.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cfg_div` in DIV_W: bit period is `cfg_div`+1 clocks.
- `cfg_data_bits` in 2: data bits per frame; 00=5, 01=6, 10=7, 11=8.
- `cfg_parity` in 2: parity mode; 00=none, 01=even, 10=odd, 11=none.
- `cfg_stop2` in 1: 1 selects two stop bits, 0 selects one.
- `wr_valid` in 1: write request.
- `wr_data` in 8: byte to send; bits above the configured data width are ignored.
- `wr_ready` out 1: FIFO not full.
- `tx` out 1: serial line, registered; idles high.
- `tx_busy` out 1: high whenever the engine is not in IDLE.
- `tx_done` out 1: one-cycle pulse when a frame's final stop bit completes.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Write handshake: a byte is accepted on any edge where `wr_valid && wr_ready`. `wr_ready = (fifo_count != FIFO_DEPTH)`.
- A write and a pop in the same cycle leave `fifo_count` unchanged. When the FIFO is full, `wr_ready` is low and nothing is written, even if a pop occurs that cycle.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1.
  - If the FIFO is non-empty, pop the head byte, latch all `cfg_*` into frame registers, and go to START.
  - Config changes mid-frame have no effect until the next pop.
- START: `tx`=0 for one bit period, then DATA.
- DATA:
  - `tx`=`data[bit_idx]`, LSB first, one bit period per bit.
  - After bit N−1 (N = latched data width), go to PARITY if parity is enabled, otherwise STOP.
- PARITY:
  - Even mode sends the XOR of the N used data bits.
  - Odd mode sends its inverse.
  - Duration is one bit period.
- STOP:
  - `tx`=1 for one bit period, or two if `cfg_stop2` was latched as 1.
  - At the end, pulse `tx_done`. If the FIFO is non-empty, pop and go directly to START (no IDLE cycle); otherwise go to IDLE.
- Bit-period counter:
  - DIV_W bits, counts 0..`cfg_div`, then clears and advances.
  - `cfg_div`=0 gives one clock per bit.
  - No other wrap case exists.
- Frame length in bit periods: 1 + N + (parity?1:0) + (stop2?2:1).

## Timing
- Reset values, applied asynchronously and immediately: `tx`=1, `tx_busy`=0, `tx_done`=0, `wr_ready`=1, `fifo_count`=0, state=IDLE. FIFO pointers and counters clear.
- Reset mid-frame aborts the frame (`tx` returns high at once) and flushes the FIFO.
- Latency from a write into an empty FIFO with the engine idle:
  - Write accepted at edge E; `fifo_count`=1 after E.
  - Pop and START entry at E+1.
  - `tx` falls at E+2.
- `tx` changes only at bit-period boundaries, so every bit lasts exactly `cfg_div`+1 clocks.
- `tx_done` is high for exactly one clock, coincident with the state leaving STOP. `tx_busy` stays high across back-to-back frames.

## Structure
- Shared package `uart_pkg`:
  - `uart_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - `parity_e` enum (PAR_NONE, PAR_EVEN, PAR_ODD).
  - Data-bits encoding constants.
  - The receiver successor will reuse this package.
- One sub-module, `uart_fifo`: synchronous FIFO with push/pop/full/empty/count, async active-high reset, parametrised on width and depth.
- Serialiser FSM and bit-period counter live in `uart_tx_fifo`.

## Test plan
- 8N1, `cfg_div`=3, write 0x55 → `tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks. Frame is 40 clocks; single `tx_done` pulse; `tx_busy` low one clock after the pulse.
- 7E2, `cfg_div`=1, write 0x41 → start, data 1,0,0,0,0,0,1, parity 0, two stop bits. Frame is 11 bits × 2 clocks.
- 5O1, `cfg_div`=0, write 0xFF → start, five 1s, parity 0, stop. Upper three bits are ignored.
- `cfg_div`=15, 10 consecutive write attempts starting at edge E → 9 accepted. `wr_ready` is low at E+9 and the 10th write stalls. The 9 frames go out back-to-back with no idle gap, with 9 `tx_done` pulses. `fifo_count` ends at 0.
- Change `cfg_data_bits` and `cfg_parity` mid-frame → the current frame is unchanged and the next frame uses the new config.
- Assert `rst` during DATA with 3 bytes queued → `tx`=1 asynchronously and `fifo_count`=0. After release, no frame is sent until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and frame-format decode helpers.
// Intended for reuse by both the transmitter and the future receiver.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  localparam logic [1:0] PAR_CODE_EVEN = 2'b01;
  localparam logic [1:0] PAR_CODE_ODD  = 2'b10;

  // Map the 2-bit parity field onto the mode enum; 00 and 11 both mean no parity.
  function automatic parity_e decode_parity(input logic [1:0] code);
    case (code)
      PAR_CODE_EVEN: return PAR_EVEN;
      PAR_CODE_ODD:  return PAR_ODD;
      default:       return PAR_NONE;
    endcase
  endfunction

  function automatic logic [2:0] last_bit_idx(input logic [1:0] dbits);
    case (dbits)
      DBITS_5: return 3'd4;
      DBITS_6: return 3'd5;
      DBITS_7: return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] data_mask(input logic [1:0] dbits);
    logic [DATA_W-1:0] ones;
    ones = '1;
    return ones >> (2'd3 - dbits);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte write port of the buffered UART transmitter (valid/ready handshake).
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is dropped, even alongside a pop.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed serialiser with runtime frame format and baud divisor.
// Frames go out back-to-back while the FIFO holds data; tx and tx_busy follow the state one clock later.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  uart_tx_fifo_if.slave                 wr_if,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  uart_state_t       state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [2:0]        last_idx_q;
  logic              stop_idx_q, stop_idx_d;
  logic [DATA_W-1:0] data_q;
  parity_e           par_q;
  logic              stop2_q;
  logic              tick;
  logic              fifo_pop;
  logic              done_d;
  logic              tx_d;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

  uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_if.wr_valid),
    .push_data (wr_if.wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wr_if.wr_ready = ~fifo_full;
  assign tick           = (cnt_q == div_q);

  // Next-state, bit sequencing and the line value for the current state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = tick ? '0 : cnt_q + DIV_W'(1);
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    fifo_pop   = 1'b0;
    done_d     = 1'b0;
    tx_d       = 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        tx_d = data_q[bit_idx_q];
        if (tick) begin
          if (bit_idx_q == last_idx_q) begin
            state_d    = (par_q == PAR_NONE) ? STOP : PARITY;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        tx_d = (^data_q) ^ (par_q == PAR_ODD);
        if (tick) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame registers are captured only on a pop, so mid-frame config changes wait for the next byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      div_q      <= '0;
      last_idx_q <= '0;
      data_q     <= '0;
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx         <= tx_d;
      tx_busy    <= (state_q != IDLE);
      tx_done    <= done_d;
      if (fifo_pop) begin
        div_q      <= cfg_div;
        last_idx_q <= last_bit_idx(cfg_data_bits);
        data_q     <= fifo_head & data_mask(cfg_data_bits);
        par_q      <= decode_parity(cfg_parity);
        stop2_q    <= cfg_stop2;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: table of single frames, burst, mid-frame config change and reset abort.
// A line monitor pops expected frames from a scoreboard and checks every sampled clock of each bit.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 16;

  typedef struct {
    int         div;
    logic [1:0] dbits;
    logic [1:0] par;
    logic       stop2;
    logic [7:0] data;
    int         nb;
    logic [11:0] bits;
  } vec_t;

  typedef struct {
    int          div;
    int          nb;
    logic [11:0] bits;
    bit          b2b;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [DW-1:0]           cfg_div;
  logic [1:0]              cfg_data_bits;
  logic [1:0]              cfg_parity;
  logic                    cfg_stop2;
  logic                    tx;
  logic                    tx_busy;
  logic                    tx_done;
  logic [$clog2(DEPTH):0]  fifo_count;

  uart_tx_fifo_if wr ();

  uart_tx_fifo #(
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_div       (cfg_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .wr_if         (wr),
    .tx            (tx),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   frames_done = 0;
  int   frame_starts = 0;
  int   stray_done = 0;
  int   gap = 1000;

  task automatic check(input bit ok, input string name, input int act, input int want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  function automatic exp_t model(input int div, input logic [1:0] dbits, input logic [1:0] par,
                                 input logic stop2, input logic [7:0] d, input bit b2b);
    exp_t e;
    int   k;
    logic p;
    e.div   = div;
    e.b2b   = b2b;
    e.bits  = '1;
    e.bits[0] = 1'b0;
    k = 1;
    p = 1'b0;
    for (int i = 0; i < 5 + int'(dbits); i++) begin
      e.bits[k] = d[i];
      p = p ^ d[i];
      k++;
    end
    if (par == 2'b01) begin
      e.bits[k] = p;
      k++;
    end else if (par == 2'b10) begin
      e.bits[k] = ~p;
      k++;
    end
    e.bits[k] = 1'b1;
    k++;
    if (stop2) begin
      e.bits[k] = 1'b1;
      k++;
    end
    e.nb = k;
    return e;
  endfunction

  task automatic write_byte(input logic [7:0] d, output logic acc);
    @(negedge clk);
    wr.wr_valid = 1'b1;
    wr.wr_data  = d;
    acc = wr.wr_ready;
    @(negedge clk);
    wr.wr_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(frames_done >= target, "frame_timeout", frames_done, target);
  endtask

  // Line monitor: one check per bit (all clocks of the bit), one for the done pulse, one for b2b gap.
  initial begin : mon
    exp_t e;
    bit   aborted;
    bit   ok;
    bit   last;
    int   bad;
    logic done_seen;
    forever begin
      @(negedge clk);
      if (rst) begin
        gap = 1000;
      end else if (tx === 1'b0) begin
        frame_starts++;
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_start", 0, 1);
          while (tx === 1'b0 && !rst) @(negedge clk);
        end else begin
          e = sb.pop_front();
          if (e.b2b) check(gap == 0, "b2b_gap", gap, 0);
          aborted   = 1'b0;
          done_seen = 1'b0;
          for (int b = 0; b < e.nb && !aborted; b++) begin
            ok  = 1'b1;
            bad = 0;
            for (int c = 0; c <= e.div; c++) begin
              if (!(b == 0 && c == 0)) @(negedge clk);
              if (rst) begin
                aborted = 1'b1;
                break;
              end
              last = (b == e.nb - 1) && (c == e.div);
              if (ok && (tx !== e.bits[b] || tx_busy !== 1'b1)) begin
                ok  = 1'b0;
                bad = {30'd0, tx_busy, tx};
              end
              if (last) done_seen = tx_done;
              else if (tx_done === 1'b1) stray_done++;
            end
            if (!aborted)
              check(ok, $sformatf("frame%0d_bit%0d_busy_tx", frame_starts, b), bad,
                    {30'd0, 1'b1, e.bits[b]});
          end
          if (!aborted) begin
            check(done_seen === 1'b1, "done_pulse", done_seen, 1);
            frames_done++;
          end
          gap = 0;
        end
      end else begin
        gap++;
        if (tx_done === 1'b1) stray_done++;
      end
    end
  end

  initial begin
    vec_t vecs[6];
    exp_t e;
    logic acc;
    int   base;
    int   starts;
    int   accepted;
    int   n;

    // {div, data_bits, parity, stop2, byte, frame bits, line bits (bit0 = start)}
    vecs[0] = '{3, 2'b11, 2'b00, 1'b0, 8'h55, 10, 12'h2AA};
    vecs[1] = '{1, 2'b10, 2'b01, 1'b1, 8'h41, 11, 12'h682};
    vecs[2] = '{0, 2'b00, 2'b10, 1'b0, 8'hFF,  8, 12'h0BE};
    vecs[3] = '{2, 2'b01, 2'b01, 1'b0, 8'h2C,  9, 12'h1D8};
    vecs[4] = '{0, 2'b11, 2'b10, 1'b1, 8'hA5, 12, 12'hF4A};
    vecs[5] = '{1, 2'b00, 2'b11, 1'b1, 8'hE3,  8, 12'h0C6};

    cfg_div       = '0;
    cfg_data_bits = 2'b11;
    cfg_parity    = 2'b00;
    cfg_stop2     = 1'b0;
    wr.wr_valid   = 1'b0;
    wr.wr_data    = '0;

    repeat (3) @(negedge clk);
    check(tx === 1'b1, "rst_tx", tx, 1);
    check(tx_busy === 1'b0, "rst_busy", tx_busy, 0);
    check(tx_done === 1'b0, "rst_done", tx_done, 0);
    check(wr.wr_ready === 1'b1, "rst_ready", wr.wr_ready, 1);
    check(fifo_count === 4'd0, "rst_count", fifo_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      cfg_div       = DW'(vecs[i].div);
      cfg_data_bits = vecs[i].dbits;
      cfg_parity    = vecs[i].par;
      cfg_stop2     = vecs[i].stop2;
      e.div  = vecs[i].div;
      e.nb   = vecs[i].nb;
      e.bits = vecs[i].bits;
      e.b2b  = 1'b0;
      sb.push_back(e);
      base = frames_done;
      write_byte(vecs[i].data, acc);
      check(acc === 1'b1, "wr_accept", acc, 1);
      if (i == 0) begin
        check(fifo_count === 4'd1, "lat_count_e", fifo_count, 1);
        check(tx === 1'b1, "lat_tx_e", tx, 1);
        @(negedge clk);
        check(fifo_count === 4'd0, "lat_count_e1", fifo_count, 0);
        check(tx === 1'b1, "lat_tx_e1", tx, 1);
        @(negedge clk);
        check(tx === 1'b0, "lat_tx_e2", tx, 0);
      end
      wait_frames(base + 1, vecs[i].nb * (vecs[i].div + 1) + 20);
      @(negedge clk);
      check(tx_busy === 1'b0, "busy_after_done", tx_busy, 0);
      check(tx === 1'b1, "idle_tx", tx, 1);
    end

    // Burst of 10 write attempts on consecutive edges, 8N1 at div 15.
    cfg_div = 16'd15;
    cfg_data_bits = 2'b11;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    base = frames_done;
    accepted = 0;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      wr.wr_valid = 1'b1;
      wr.wr_data  = 8'(16 + 7 * k);
      acc = wr.wr_ready;
      if (k == 9) check(acc === 1'b0, "wr_ready_full", acc, 0);
      if (acc) begin
        accepted++;
        sb.push_back(model(15, 2'b11, 2'b00, 1'b0, wr.wr_data, accepted > 1));
      end
      @(negedge clk);
    end
    wr.wr_valid = 1'b0;
    check(accepted == 9, "burst_accepted", accepted, 9);
    check(fifo_count === 4'd8, "burst_count_full", fifo_count, 8);
    wait_frames(base + 9, 9 * 160 + 100);
    check(frames_done - base == 9, "burst_done_count", frames_done - base, 9);
    check(fifo_count === 4'd0, "burst_count_end", fifo_count, 0);
    @(negedge clk);
    check(tx_busy === 1'b0, "burst_busy_after", tx_busy, 0);

    // Config change while the first frame is in flight only affects the queued byte.
    cfg_div = 16'd2;
    cfg_data_bits = 2'b11;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    base = frames_done;
    starts = frame_starts;
    sb.push_back(model(2, 2'b11, 2'b00, 1'b0, 8'h3C, 1'b0));
    write_byte(8'h3C, acc);
    write_byte(8'hC3, acc);
    n = 0;
    while (frame_starts == starts && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    cfg_div = 16'd1;
    cfg_data_bits = 2'b01;
    cfg_parity = 2'b01;
    cfg_stop2 = 1'b1;
    sb.push_back(model(1, 2'b01, 2'b01, 1'b1, 8'hC3, 1'b1));
    wait_frames(base + 2, 200);

    // Reset during DATA with three bytes queued.
    cfg_div = 16'd3;
    cfg_data_bits = 2'b11;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    sb.push_back(model(3, 2'b11, 2'b00, 1'b0, 8'h11, 1'b0));
    write_byte(8'h11, acc);
    write_byte(8'h22, acc);
    write_byte(8'h33, acc);
    write_byte(8'h44, acc);
    check(fifo_count === 4'd3, "pre_rst_count", fifo_count, 3);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check(tx === 1'b1, "async_rst_tx", tx, 1);
    check(fifo_count === 4'd0, "async_rst_count", fifo_count, 0);
    check(tx_busy === 1'b0, "async_rst_busy", tx_busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    starts = frame_starts;
    repeat (100) @(negedge clk);
    check(frame_starts == starts, "no_frame_after_rst", frame_starts - starts, 0);
    check(tx === 1'b1, "post_rst_tx", tx, 1);
    check(fifo_count === 4'd0, "post_rst_count", fifo_count, 0);

    check(stray_done == 0, "stray_done", stray_done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
